ssg_scan_decoder: RTL and testbench
===================================

// Module: ssg_scan_decoder
// PURPOSE
//  Receiving end of the board's multiplexed 7-segment interface (an/ssg).
//  Samples the scanned an/ssg lines, decodes each segment pattern back to a hex nibble
//  and assembles complete 4-digit frames.
//  Used as an on-chip loopback checker and as the self-checking monitor in display benches.
// PARAMETERS
//  SETTLE_CYC  4  consecutive stable cycles required before an/ssg are sampled (>=1)
//  ACT_LOW     1  1: an and ssg are active-low (board polarity); 0: active-high
// PORTS
//  mclk         in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  an           in   4   anode lines; an[i] selects digit i (digit 3 = MSB nibble)
//  ssg          in   8   segments: [7]=dp, [6:0]=g,f,e,d,c,b,a
//  clr          in   1   sync clear: err, seen mask and shadow registers
//  digits       out  16  last complete frame: {d3,d2,d1,d0}
//  dp           out  4   decimal point per digit, last frame
//  blank        out  4   digit was all-segments-off, last frame
//  frame_valid  out  1   1-cycle pulse when digits/dp/blank update
//  err          out  1   sticky: stable multi-anode or unknown pattern
// BEHAVIOUR
//  - Reset: digits=0, dp=0, blank=0, frame_valid=0, err=0, seen=0, FSM=IDLE, sync regs=idle level.
//  - an/ssg pass a 2-FF synchronizer, then are normalized to active-high (inverted if ACT_LOW).
//  - Stability counter: cleared when synced {an,ssg} changes; otherwise increments, saturating at SETTLE_CYC.
//  - FSM:
//      IDLE    : no anode active; -> SETTLE when >=1 anode active.
//      SETTLE  : waits for the counter to reach SETTLE_CYC.
//                Then exactly one anode -> sample, -> HOLD.
//                Then >1 anode -> err=1, no sample, -> HOLD.
//                Any input change restarts the count in SETTLE.
//      HOLD    : no further samples until the inputs change; change -> SETTLE (or IDLE if no anode).
//  - Sample of digit i:
//      known hex pattern -> shadow nibble[i]=value, blank[i]=0.
//      all-off pattern   -> nibble 0, blank[i]=1.
//      dp shadow[i]=ssg[7]; seen[i]=1.
//      unknown pattern   -> err=1; nibble, seen and dp unchanged.
//  - Pattern table (active-high gfedcba):
//      0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//      8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  - Resampling a digit before the frame completes overwrites its shadow entry.
//  - Frame completion: cycle after seen becomes 4'b1111.
//      Shadow copies atomically to digits/dp/blank, frame_valid=1 for one cycle, seen=0.
//      Outputs are otherwise held.
//  - Latency: input edge -> sample = 2 + SETTLE_CYC cycles; 4th sample -> frame_valid +1 cycle.
//  - clr has priority over sampling and frame completion in the same cycle:
//      frame_valid stays 0; digits/dp/blank are NOT cleared.
//  - Async reset mid-frame discards the partial frame.
// TESTING
//  1 Reset with a frame in flight (2 digits seen) -> all outputs 0; next full frame needed for frame_valid.
//  2 ACT_LOW=1: an=E,ssg=C0 / an=D,F9 / an=B,A4 / an=7,B0, 10 cycles each
//      -> one frame_valid pulse, digits=16'h3210, dp=0, blank=0, err=0.
//  3 an=E,ssg=F9 for 2 cycles between idle (an=F) periods, SETTLE_CYC=4
//      -> no sample; seen unchanged, no pulse.
//  4 an=E,ssg=FE (segment a only) stable -> err=1 and stays 1; clr pulse -> err=0.
//  5 an=C stable 10 cycles -> err=1, seen unchanged; an=F stable -> FSM IDLE, no sample.
//  6 Frame with d0 ssg=40 (0+dp), d1 ssg=FF (blank), d2=A4, d3=B0
//      -> digits=16'h3200, dp=4'b0001, blank=4'b0010.

Source files
------------

// File: rtl/ssg_scan_decoder.sv
`default_nettype none
// ============================================================================
// ssg_scan_decoder : samples a scanned an/ssg 7-segment bus, decodes digits
//                    and assembles complete 4-digit frames.
// Revision 1.0
// ============================================================================
module ssg_scan_decoder #(
    parameter int SETTLE_CYC = 4,
    parameter bit ACT_LOW    = 1'b1
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  ssg,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        err
);

    localparam int               CNT_W      = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYC);
    localparam logic [11:0]      IDLE_LVL   = ACT_LOW ? 12'hFFF : 12'h000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [11:0]      sync1, sync2;
    logic [11:0]      act_cur, act_new;
    logic [3:0]       an_act;
    logic [7:0]       seg_act;
    logic             changed;
    logic [CNT_W-1:0] cnt;
    logic             do_sample, multi;
    logic [1:0]       idx;
    logic [4:0]       dec;
    logic             blank_pat, take, bad, complete;
    logic [3:0]       seen;
    logic [3:0][3:0]  sh_nib;
    logic [3:0]       sh_dp, sh_blank;

    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h00;
        case (seg)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h07: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= {an, ssg};
            sync2 <= sync1;
        end
    end

    // Change is detected one stage early so the count clears as sync2 updates.
    assign changed = (sync1 != sync2);
    assign act_cur = ACT_LOW ? ~sync2 : sync2;
    assign act_new = ACT_LOW ? ~sync1 : sync1;
    assign an_act  = act_cur[11:8];
    assign seg_act = act_cur[7:0];

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= '0;
        end else if (cnt != SETTLE_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        do_sample = 1'b0;
        multi     = 1'b0;
        case (state)
            IDLE: begin
                if (an_act != 4'h0) state_nx = SETTLE;
            end
            SETTLE: begin
                if (an_act == 4'h0) begin
                    state_nx = IDLE;
                end else if ((cnt == SETTLE_MAX) && !changed) begin
                    if ($onehot(an_act)) do_sample = 1'b1;
                    else                 multi     = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (changed) state_nx = (act_new[11:8] == 4'h0) ? IDLE : SETTLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_act[i]) idx = 2'(i);
        end
    end

    assign dec       = decode_seg(seg_act[6:0]);
    assign blank_pat = (seg_act[6:0] == 7'h00);
    assign take      = do_sample && (dec[4] || blank_pat);
    assign bad       = multi || (do_sample && !take);
    assign complete  = (seen == 4'hF);

    // clr wins over sampling and frame completion; published outputs are kept.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            dp          <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            seen        <= '0;
            sh_nib      <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (clr) begin
                err      <= 1'b0;
                seen     <= '0;
                sh_nib   <= '0;
                sh_dp    <= '0;
                sh_blank <= '0;
            end else begin
                if (bad) err <= 1'b1;
                if (complete) begin
                    digits      <= sh_nib;
                    dp          <= sh_dp;
                    blank       <= sh_blank;
                    frame_valid <= 1'b1;
                end
                seen <= (complete ? 4'h0 : seen) | (take ? an_act : 4'h0);
                if (take) begin
                    sh_nib[idx]   <= blank_pat ? 4'h0 : dec[3:0];
                    sh_dp[idx]    <= seg_act[7];
                    sh_blank[idx] <= blank_pat;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssg_scan_decoder.sv
`default_nettype none
// Bench for ssg_scan_decoder: frame-level model plus directed board-polarity vectors.
module tb_ssg_scan_decoder;

    localparam int SETTLE   = 4;
    localparam int LONG     = 12;
    localparam int LONG_MIN = 8;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [7:0]  ssg;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        err;

    always #5 mclk = ~mclk;

    ssg_scan_decoder #(.SETTLE_CYC(SETTLE), .ACT_LOW(1'b1)) dut (
        .mclk(mclk), .rst_n(rst_n), .an(an), .ssg(ssg), .clr(clr),
        .digits(digits), .dp(dp), .blank(blank),
        .frame_valid(frame_valid), .err(err)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
    } frame_t;

    int     checks = 0;
    int     errors = 0;
    int     n_pulse = 0;
    int     n_exp = 0;
    bit     run = 1'b0;
    frame_t exp_q[$];
    frame_t cur;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] m_nib [4];
    logic [3:0] m_dp, m_blank, m_seen;
    logic       m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Board-level model: one long stable single-anode period yields one sample.
    task automatic model_sample(input logic [3:0] an_b, input logic [7:0] ssg_b);
        logic [3:0] a;
        logic [7:0] s;
        logic [3:0] nib;
        int         i_d;
        bit         ok;
        a = ~an_b;
        s = ~ssg_b;
        if ($countones(a) == 0) return;
        if ($countones(a) > 1) begin
            m_err = 1'b1;
            return;
        end
        i_d = 0;
        for (int i = 0; i < 4; i++) if (a[i]) i_d = i;
        ok  = (s[6:0] == 7'h00);
        nib = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (pat[v] == s[6:0]) begin
                ok  = 1'b1;
                nib = 4'(v);
            end
        end
        if (!ok) begin
            m_err = 1'b1;
            return;
        end
        m_nib[i_d]   = nib;
        m_dp[i_d]    = s[7];
        m_blank[i_d] = (s[6:0] == 7'h00);
        m_seen[i_d]  = 1'b1;
        if (m_seen == 4'hF) begin
            exp_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0], m_dp, m_blank});
            n_exp++;
            m_seen = 4'h0;
        end
    endtask

    task automatic model_clear();
        m_err   = 1'b0;
        m_seen  = 4'h0;
        m_dp    = 4'h0;
        m_blank = 4'h0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    endtask

    task automatic step(input logic [3:0] an_b, input logic [7:0] ssg_b, input int n);
        an  = an_b;
        ssg = ssg_b;
        if (n >= LONG_MIN) model_sample(an_b, ssg_b);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
        if (n >= LONG_MIN) check("err_after_step", 32'(err), 32'(m_err));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        an    = 4'hF;
        ssg   = 8'hFF;
        clr   = 1'b0;
        model_clear();
        cur = '0;
        exp_q.delete();
        #2;
        check("reset_outputs", {11'h0, digits, dp, blank, frame_valid, err}, 32'h0);
        repeat (2) begin
            @(posedge mclk);
            #1;
        end
        run = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge mclk);
        #1;
        clr = 1'b0;
        model_clear();
        check("err_after_clr", 32'(err), 32'h0);
    endtask

    always @(negedge mclk) begin
        if (run) begin
            if (frame_valid === 1'b1) begin
                n_pulse++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got digits=%h dp=%b blank=%b, required no pulse",
                             digits, dp, blank);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            check("frame_outputs", {8'h0, digits, dp, blank}, {8'h0, cur});
        end
    end

    initial begin
        reset_dut();

        // Plain frame 3,2,1,0
        step(4'hF, 8'hFF, LONG);
        step(4'hE, 8'hC0, LONG);
        step(4'hD, 8'hF9, LONG);
        step(4'hB, 8'hA4, LONG);
        step(4'h7, 8'hB0, LONG);
        step(4'hF, 8'hFF, LONG);
        check("t2_digits", 32'(digits), 32'h3210);
        check("t2_dp_blank", {24'h0, dp, blank}, 32'h0);
        check("t2_err", 32'(err), 32'h0);
        check("t2_pulses", 32'(n_pulse), 32'd1);

        // Reset with two digits in flight discards them
        step(4'hE, 8'h99, LONG);
        step(4'hD, 8'h92, LONG);
        reset_dut();
        check("t1_digits_zero", 32'(digits), 32'h0);
        step(4'hF, 8'hFF, LONG);
        step(4'hB, 8'h82, LONG);
        step(4'h7, 8'hF8, LONG);
        check("t1_no_early_frame", 32'(n_pulse), 32'd1);
        step(4'hE, 8'h80, LONG);
        step(4'hD, 8'h90, LONG);
        step(4'hF, 8'hFF, LONG);
        check("t1_digits", 32'(digits), 32'h7698);
        check("t1_pulses", 32'(n_pulse), 32'd2);

        // Short glitch on the last missing digit must not be sampled
        step(4'hE, 8'hC0, LONG);
        step(4'hD, 8'hF9, LONG);
        step(4'hB, 8'hA4, LONG);
        step(4'hF, 8'hFF, LONG);
        step(4'h7, 8'hF9, 2);
        step(4'hF, 8'hFF, LONG);
        check("t3_no_pulse", 32'(n_pulse), 32'd2);
        step(4'h7, 8'hB0, LONG);
        step(4'hF, 8'hFF, LONG);
        check("t3_pulses", 32'(n_pulse), 32'd3);

        // Unknown pattern makes err sticky until clr
        step(4'hE, 8'hFE, LONG);
        check("t4_err_set", 32'(err), 32'h1);
        step(4'hF, 8'hFF, LONG);
        check("t4_err_sticky", 32'(err), 32'h1);
        clr_pulse();

        // Multi-anode sets err, samples nothing
        step(4'hE, 8'h88, LONG);
        step(4'hD, 8'h83, LONG);
        step(4'hC, 8'h86, LONG);
        check("t5_err_multi", 32'(err), 32'h1);
        step(4'hF, 8'hFF, LONG);
        step(4'hB, 8'hC6, LONG);
        step(4'h7, 8'hA1, LONG);
        step(4'hF, 8'hFF, LONG);
        check("t5_digits", 32'(digits), 32'hDCBA);
        check("t5_pulses", 32'(n_pulse), 32'd4);
        clr_pulse();

        // clr mid-frame forgets seen digits
        step(4'hE, 8'h86, LONG);
        step(4'hD, 8'h8E, LONG);
        clr_pulse();
        step(4'hB, 8'hF9, LONG);
        step(4'h7, 8'hC0, LONG);
        step(4'hF, 8'hFF, LONG);
        check("clr_no_frame", 32'(n_pulse), 32'd4);
        step(4'hE, 8'hC0, LONG);
        step(4'hD, 8'hF9, LONG);
        step(4'hF, 8'hFF, LONG);
        check("clr_frame_digits", 32'(digits), 32'h0110);

        // dp and blank digits
        step(4'hE, 8'h40, LONG);
        step(4'hD, 8'hFF, LONG);
        step(4'hB, 8'hA4, LONG);
        step(4'h7, 8'hB0, LONG);
        step(4'hF, 8'hFF, LONG);
        check("t6_digits", 32'(digits), 32'h3200);
        check("t6_dp", 32'(dp), 32'b0001);
        check("t6_blank", 32'(blank), 32'b0010);

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        check("total_pulses", 32'(n_pulse), 32'(n_exp));
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
